// File: rtl/switch_debounce_sync.sv
// Two-flop synchroniser and per-vector stability debouncer for the slide switches, with a valid/ack change event.
// Optional macro DEBOUNCE_RISE_MASK_EN adds evt_rise, the accumulated 0->1 bits since the last acknowledge.
module switch_debounce_sync #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_db,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_data,
    input  logic             evt_ack,
    output logic             evt_overrun
`ifdef DEBOUNCE_RISE_MASK_EN
    ,
    output logic [WIDTH-1:0] evt_rise
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sw_db_q, sw_db_d;
    logic             evt_valid_q, evt_valid_d;
    logic [WIDTH-1:0] evt_data_q, evt_data_d;
    logic             evt_overrun_q, evt_overrun_d;
    logic             accept;
    logic             ack_hit;

    // Debounce: any change of the synchronised vector restarts the count; a
    // candidate equal to sw_db is not counted at all.
    always_comb begin
        s1_d    = sw_in;
        s2_d    = s1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        sw_db_d = sw_db_q;
        accept  = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cand_q != sw_db_q) begin
            if (cnt_q == CNT_LAST) begin
                sw_db_d = cand_q;
                cnt_d   = '0;
                accept  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Event handshake: evt_valid holds with evt_data until a cycle where
    // evt_ack=1 while evt_valid=1; an accept in that same cycle re-arms the
    // event with the new value instead of counting as an overrun.
    assign ack_hit = evt_valid_q & evt_ack;

    always_comb begin
        evt_valid_d   = evt_valid_q;
        evt_data_d    = evt_data_q;
        evt_overrun_d = evt_overrun_q;
        if (accept) begin
            evt_valid_d = 1'b1;
            evt_data_d  = sw_db_d;
            if (evt_valid_q && !evt_ack) begin
                evt_overrun_d = 1'b1;
            end else if (ack_hit) begin
                evt_overrun_d = 1'b0;
            end
        end else if (ack_hit) begin
            evt_valid_d   = 1'b0;
            evt_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q          <= '0;
            s2_q          <= '0;
            cand_q        <= '0;
            cnt_q         <= '0;
            sw_db_q       <= '0;
            evt_valid_q   <= 1'b0;
            evt_data_q    <= '0;
            evt_overrun_q <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            sw_db_q       <= sw_db_d;
            evt_valid_q   <= evt_valid_d;
            evt_data_q    <= evt_data_d;
            evt_overrun_q <= evt_overrun_d;
        end
    end

    assign sw_db       = sw_db_q;
    assign evt_valid   = evt_valid_q;
    assign evt_data    = evt_data_q;
    assign evt_overrun = evt_overrun_q;

`ifdef DEBOUNCE_RISE_MASK_EN
    logic [WIDTH-1:0] evt_rise_q, evt_rise_d;
    logic [WIDTH-1:0] rise_bits;

    always_comb begin
        rise_bits  = sw_db_d & ~sw_db_q;
        evt_rise_d = evt_rise_q;
        if (accept) begin
            evt_rise_d = ack_hit ? rise_bits : (evt_rise_q | rise_bits);
        end else if (ack_hit) begin
            evt_rise_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_rise_q <= '0;
        end else begin
            evt_rise_q <= evt_rise_d;
        end
    end

    assign evt_rise = evt_rise_q;
`endif

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Bench for switch_debounce_sync: directed cases from the plan, then random switch traffic
// against a run-length reference model with a scoreboard of accepted values.
module tb_switch_debounce_sync;

  localparam int W       = 8;
  localparam int STABLE  = 4;
  localparam int RUN_SAT = STABLE + 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_in;
  logic [W-1:0] sw_db;
  logic         evt_valid;
  logic [W-1:0] evt_data;
  logic         evt_ack;
  logic         evt_overrun;
`ifdef DEBOUNCE_RISE_MASK_EN
  logic [W-1:0] evt_rise;
`endif

  switch_debounce_sync #(.WIDTH(W), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_in       (sw_in),
    .sw_db       (sw_db),
    .evt_valid   (evt_valid),
    .evt_data    (evt_data),
    .evt_ack     (evt_ack),
    .evt_overrun (evt_overrun)
`ifdef DEBOUNCE_RISE_MASK_EN
    ,
    .evt_rise    (evt_rise)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a value is accepted once the synchronised stream has
  // shown it for STABLE+1 consecutive edges and it differs from sw_db
  logic [W-1:0] m_d1, m_d2, m_run_val, m_db, m_data, m_rise;
  int           m_run_len;
  logic         m_valid, m_over;

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_run_val = '0; m_run_len = RUN_SAT;
    m_db = '0; m_data = '0; m_rise = '0; m_valid = 1'b0; m_over = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [W-1:0] seen, rise;
    logic acc;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        seen = m_d2;
        m_d2 = m_d1;
        m_d1 = sw_in;
        if (seen == m_run_val) begin
          if (m_run_len < RUN_SAT) m_run_len++;
        end else begin
          m_run_val = seen;
          m_run_len = 1;
        end
        acc = (m_run_len == STABLE + 1) && (m_run_val != m_db);
        if (acc) begin
          rise   = m_run_val & ~m_db;
          m_rise = (m_valid && !evt_ack) ? (m_rise | rise) : rise;
          m_over = m_valid && !evt_ack;
          m_valid = 1'b1;
          m_data = m_run_val;
          m_db   = m_run_val;
          exp_q.push_back(m_run_val);
        end else if (m_valid && evt_ack) begin
          m_valid = 1'b0;
          m_over  = 1'b0;
          m_rise  = '0;
        end
      end
    end
  end

  // monitor: per-cycle compare against the model, and pop the scoreboard
  // whenever sw_db presents a new value
  initial begin
    logic [W-1:0] prev_db, e;
    prev_db = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        check("mon_sw_db", 32'(sw_db), 32'(m_db));
        check("mon_evt_valid", 32'(evt_valid), 32'(m_valid));
        check("mon_evt_data", 32'(evt_data), 32'(m_data));
        check("mon_evt_overrun", 32'(evt_overrun), 32'(m_over));
`ifdef DEBOUNCE_RISE_MASK_EN
        check("mon_evt_rise", 32'(evt_rise), 32'(m_rise));
`endif
        if (sw_db != prev_db) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_change", 32'(sw_db), 32'(prev_db));
          end else begin
            e = exp_q.pop_front();
            check("sb_db", 32'(sw_db), 32'(e));
            check("sb_evt_data", 32'(evt_data), 32'(e));
          end
        end
      end
      prev_db = sw_db;
    end
  end

  // drivers
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sw_db"}, 32'(sw_db), 32'h0);
    check({tag, "_evt_valid"}, 32'(evt_valid), 32'h0);
    check({tag, "_evt_data"}, 32'(evt_data), 32'h0);
    check({tag, "_evt_overrun"}, 32'(evt_overrun), 32'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    sw_in   = 8'hA5;
    evt_ack = 1'b0;
    hold(3);
    check_all_zero("rst");
    rst_n = 1'b1;
    hold(6);
    check("rst_lat_e6", 32'(sw_db), 32'h00);
    hold(1);
    check("rst_lat_e7", 32'(sw_db), 32'hA5);
    check("rst_valid", 32'(evt_valid), 32'h1);
    check("rst_data", 32'(evt_data), 32'hA5);
    ack_pulse();
    check("rst_ack_valid", 32'(evt_valid), 32'h0);

    // single-bit rise, exact latency
    sw_in = 8'h00;
    hold(10);
    ack_pulse();
    sw_in = 8'h01;
    hold(6);
    check("lat_e6_db", 32'(sw_db), 32'h00);
    check("lat_e6_valid", 32'(evt_valid), 32'h0);
    hold(1);
    check("lat_e7_db", 32'(sw_db), 32'h01);
    check("lat_e7_valid", 32'(evt_valid), 32'h1);
    check("lat_e7_over", 32'(evt_overrun), 32'h0);
    ack_pulse();

    // short glitch never reaches sw_db
    sw_in = 8'h00;
    hold(10);
    ack_pulse();
    sw_in = 8'h01;
    hold(3);
    sw_in = 8'h00;
    hold(12);
    check("glitch_db", 32'(sw_db), 32'h00);
    check("glitch_valid", 32'(evt_valid), 32'h0);

    // overrun, then ack clears
    sw_in = 8'h0F;
    hold(10);
    sw_in = 8'hF0;
    hold(10);
    check("ovr_data", 32'(evt_data), 32'hF0);
    check("ovr_flag", 32'(evt_overrun), 32'h1);
    ack_pulse();
    check("ovr_ack_valid", 32'(evt_valid), 32'h0);
    check("ovr_ack_flag", 32'(evt_overrun), 32'h0);

    // ack on the accept edge
    sw_in = 8'h11;
    hold(10);
    sw_in = 8'h3C;
    hold(6);
    evt_ack = 1'b1;
    hold(1);
    evt_ack = 1'b0;
    check("same_valid", 32'(evt_valid), 32'h1);
    check("same_data", 32'(evt_data), 32'h3C);
    check("same_over", 32'(evt_overrun), 32'h0);

    // reset mid-count
    sw_in = 8'h80;
    hold(4);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    hold(1);
    rst_n = 1'b1;
    hold(6);
    check("rst2_e6_db", 32'(sw_db), 32'h00);
    hold(1);
    check("rst2_e7_db", 32'(sw_db), 32'h80);
    check("rst2_valid", 32'(evt_valid), 32'h1);

    // random traffic: stable values, glitches and random acks
    for (int i = 0; i < 300; i++) begin
      int len;
      if ($urandom_range(0, 3) == 0) sw_in = sw_in ^ (8'h1 << $urandom_range(0, 7));
      else sw_in = 8'($urandom);
      len = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        evt_ack = ($urandom_range(0, 2) == 0);
        @(negedge clk);
      end
    end
    evt_ack = 1'b0;
    hold(12);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
